// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem port, IF/ID register
//
// Owns the PC, drives the synchronous instruction memory and registers each
// fetched word with its PC and a valid flag into the IF/ID boundary.
// Optional feature macro: FETCH_HALT_EN (halt detection on HALT_OPCODE).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   stall                         hold IF/ID contents and PC
//   jump, jump_target             unconditional redirect (wins over branch)
//   branch_taken, branch_target   resolved taken branch redirect
//   imem_en, imem_addr            memory read enable / word address
//   imem_rdata                    memory data, one cycle after enabled address
//   instr, opcode                 IF/ID instruction and its top 3 bits
//   instr_pc, instr_valid         PC of instr, instr is real (not squashed)
//   halted                        fetch stopped in HALT (0 without macro)
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [ADDR_W-1:0]   fetched_pc, fetched_pc_nxt;
  logic                inflight, inflight_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic [ADDR_W-1:0]   instr_pc_nxt;
  logic                instr_valid_nxt;

  logic                redirect;
  logic [ADDR_W-1:0]   target;
  logic                halt_hit;

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
  assign halted = (state == S_HALT);
`else
  localparam logic HALT_EN = 1'b0;
  assign halted = 1'b0;
`endif

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  // Redirect target goes straight to the memory so the new stream costs
  // only one bubble instead of two.
  assign imem_addr = redirect ? target : pc;
  assign imem_en   = ~reset & (redirect | (~stall & (state != S_HALT)));

  assign opcode = instr[INSTR_W-1 -: 3];

  // The word on imem_rdata is a live HALT instruction.
  assign halt_hit = HALT_EN & inflight & (imem_rdata[INSTR_W-1 -: 3] == HALT_OPCODE);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetched_pc_nxt  = fetched_pc;
    inflight_nxt    = inflight;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;

    if (redirect) begin
      // Squash IF/ID; the target word is already being read this cycle.
      instr_nxt       = '0;
      instr_valid_nxt = 1'b0;
      fetched_pc_nxt  = target;
      inflight_nxt    = 1'b1;
      pc_nxt          = target + ADDR_W'(1);
      state_nxt       = S_RUN;
    end else if (!stall) begin
      case (state)
        S_BOOT: begin
          fetched_pc_nxt  = pc;
          inflight_nxt    = 1'b1;
          pc_nxt          = pc + ADDR_W'(1);
          instr_valid_nxt = 1'b0;
          state_nxt       = S_RUN;
        end
        S_RUN: begin
          instr_nxt       = imem_rdata;
          instr_pc_nxt    = fetched_pc;
          instr_valid_nxt = inflight;
          fetched_pc_nxt  = pc;
          inflight_nxt    = 1'b1;
          pc_nxt          = pc + ADDR_W'(1);
          if (halt_hit) begin
            // HALT itself is passed on; the word fetched behind it is dead.
            inflight_nxt = 1'b0;
            state_nxt    = S_HALT;
          end
        end
        S_HALT: begin
          instr_valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      fetched_pc  <= '0;
      inflight    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetched_pc  <= fetched_pc_nxt;
      inflight    <= inflight_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;
  bit halt_mode = 1'b0;

`ifdef FETCH_HALT_EN
  localparam bit HALT_MODEL = 1'b1;
`else
  localparam bit HALT_MODEL = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_mode && a == 16'h0003) return 16'hE000;
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: the word last requested from memory, the next
  // sequential address, and what IF/ID must show.
  bit          model_ok = 1'b0;
  logic [15:0] m_next, m_slot, m_instr, m_ipc;
  bit          m_live, m_valid, m_boot, m_halt;

  always @(posedge clk) begin
    logic [15:0] w;
    if (reset) begin
      m_next = 16'h0000; m_slot = '0; m_live = 0;
      m_instr = '0; m_ipc = '0; m_valid = 0; m_boot = 1; m_halt = 0;
      model_ok = 1'b1;
    end else if (jump || branch_taken) begin
      m_slot  = jump ? jump_target : branch_target;
      m_live  = 1;
      m_next  = m_slot + 16'd1;
      m_instr = '0; m_valid = 0; m_boot = 0; m_halt = 0;
    end else if (!stall) begin
      if (m_halt) begin
        m_valid = 0;
      end else if (m_boot) begin
        m_slot = m_next; m_live = 1; m_next = m_next + 16'd1;
        m_valid = 0; m_boot = 0;
      end else begin
        w = mem_word(m_slot);
        m_instr = w; m_ipc = m_slot; m_valid = m_live;
        if (HALT_MODEL && m_live && w[15:13] == 3'b111) begin
          m_halt = 1; m_live = 0;
        end else begin
          m_slot = m_next; m_live = 1; m_next = m_next + 16'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          e_en;
    logic [15:0] e_addr;
    if (model_ok) begin
      e_en   = !reset && (jump || branch_taken || (!stall && !m_halt));
      e_addr = jump ? jump_target : (branch_taken ? branch_target : m_next);
      check("m_imem_en", imem_en, e_en);
      if (e_en) check("m_imem_addr", imem_addr, e_addr);
      check("m_instr_valid", instr_valid, m_valid);
      check("m_instr", instr, m_instr);
      check("m_opcode", opcode, m_instr[15:13]);
      if (m_valid) check("m_instr_pc", instr_pc, m_ipc);
      check("m_halted", halted, m_halt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and in-order streaming
    reset = 1'b1;
    repeat (3) step();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_en", imem_en, 1'b0);
    reset = 1'b0;
    #1;
    check("boot_addr", imem_addr, 16'h0000);
    check("boot_en", imem_en, 1'b1);
    step();
    check("e1_addr", imem_addr, 16'h0001);
    check("e1_valid", instr_valid, 1'b0);
    step();
    check("e2_instr", instr, 16'h1000);
    check("e2_pc", instr_pc, 16'h0000);
    check("e2_valid", instr_valid, 1'b1);
    check("e2_addr", imem_addr, 16'h0002);
    step();
    check("e3_pc", instr_pc, 16'h0001);
    repeat (4) step();
    check("pre_stall_pc", instr_pc, 16'h0005);

    // Stall three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_en", imem_en, 1'b0);
      step();
      check("stall_pc", instr_pc, 16'h0005);
      check("stall_instr", instr, 16'h1005);
    end
    stall = 1'b0;
    step();
    check("post_stall_pc", instr_pc, 16'h0006);
    check("post_stall_valid", instr_valid, 1'b1);
    step();
    check("pre_br_pc", instr_pc, 16'h0007);

    // Taken branch
    branch_taken = 1'b1; branch_target = 16'h0040;
    #1;
    check("br_addr", imem_addr, 16'h0040);
    step();
    branch_taken = 1'b0;
    check("br_bubble", instr_valid, 1'b0);
    step();
    check("br_pc", instr_pc, 16'h0040);
    check("br_instr", instr, 16'h1040);
    check("br_valid", instr_valid, 1'b1);

    // Jump wins over branch, stall ignored
    jump = 1'b1; jump_target = 16'h0100;
    branch_taken = 1'b1; branch_target = 16'h0200; stall = 1'b1;
    #1;
    check("jb_addr", imem_addr, 16'h0100);
    check("jb_en", imem_en, 1'b1);
    step();
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    check("jb_bubble", instr_valid, 1'b0);
    step();
    check("jb_pc", instr_pc, 16'h0100);
    step();
    check("jb_pc2", instr_pc, 16'h0101);

    // Address wrap
    jump = 1'b1; jump_target = 16'hFFFE;
    step();
    jump = 1'b0;
    step();
    check("wr_pc0", instr_pc, 16'hFFFE);
    check("wr_addr", imem_addr, 16'h0000);
    step();
    check("wr_pc1", instr_pc, 16'hFFFF);
    check("wr_valid1", instr_valid, 1'b1);
    step();
    check("wr_pc2", instr_pc, 16'h0000);
    check("wr_valid2", instr_valid, 1'b1);

    // Reset during a stall discards the in-flight word
    stall = 1'b1; reset = 1'b1;
    step();
    stall = 1'b0; reset = 1'b0;
    check("mr_valid", instr_valid, 1'b0);
    check("mr_instr", instr, 16'h0000);
    step();
    step();
    check("mr_pc", instr_pc, 16'h0000);
    check("mr_valid2", instr_valid, 1'b1);

`ifdef FETCH_HALT_EN
    // HALT at word 3, then jump out
    reset = 1'b1; halt_mode = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    check("h_pc", instr_pc, 16'h0003);
    check("h_valid", instr_valid, 1'b1);
    check("h_instr", instr, 16'hE000);
    check("h_halted", halted, 1'b1);
    check("h_en", imem_en, 1'b0);
    step();
    check("h_valid_off", instr_valid, 1'b0);
    step();
    check("h_still", halted, 1'b1);
    jump = 1'b1; jump_target = 16'h0010;
    #1;
    check("h_jaddr", imem_addr, 16'h0010);
    check("h_jen", imem_en, 1'b1);
    step();
    jump = 1'b0;
    check("h_exit", halted, 1'b0);
    check("h_bubble", instr_valid, 1'b0);
    step();
    check("h_res_pc", instr_pc, 16'h0010);
    check("h_res_instr", instr, 16'h1010);
    check("h_res_valid", instr_valid, 1'b1);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit Harvard core. Sits directly upstream of the control/decode unit.
- Owns the PC and drives the synchronous instruction memory port.
- Registers each fetched word, with its PC and a valid flag, into the IF/ID boundary. Exposes the 3-bit opcode field straight to the control unit's opcode input.
- Handles stall, jump/branch redirect with wrong-path squash and, optionally, halt detection.

Parameters:
- ADDR_W, 16: PC and instruction-memory word-address width.
- INSTR_W, 16: instruction width; opcode is instr[INSTR_W-1:INSTR_W-3].
- RESET_PC, 16'h0000: PC loaded on reset.
- HALT_OPCODE, 3'b111: opcode treated as HALT when FETCH_HALT_EN is defined.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  downstream hazard; hold the IF/ID contents and PC
- jump  in  1  unconditional redirect request
- jump_target  in  ADDR_W  jump destination word address
- branch_taken  in  1  resolved taken branch
- branch_target  in  ADDR_W  branch destination word address
- imem_en  out  1  memory read enable; memory holds imem_rdata when 0
- imem_addr  out  ADDR_W  memory word address
- imem_rdata  in  INSTR_W  memory data, valid one cycle after the enabled address
- instr  out  INSTR_W  IF/ID instruction register
- opcode  out  3  instr[INSTR_W-1:INSTR_W-3], wired to the control unit opcode
- instr_pc  out  ADDR_W  PC of instr
- instr_valid  out  1  instr is a real, non-squashed instruction
- halted  out  1  fetch stopped in HALT state (constant 0 without macro)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset, and overrides everything.
- Reset values: pc=RESET_PC; fetched_pc=0; inflight=0; instr=0; instr_pc=0; instr_valid=0; state=BOOT; halted=0.
  - imem_en=0 while reset is high.
- Internal registers: pc (next address to fetch); fetched_pc / inflight (address and validity of the word currently on imem_rdata).
- redirect = jump | branch_taken. Target selection: jump_target if jump=1, else branch_target. Jump wins when both are asserted.
- imem_addr = redirect ? target : pc (combinational bypass, saves one bubble).
- imem_en = ~reset & (redirect | (~stall & state!=HALT)).
- FSM states:
  - BOOT: first cycle after reset. imem_en=1, addr=pc. At the edge: fetched_pc<=pc, inflight<=1, pc<=pc+1, instr_valid<=0, go RUN.
  - RUN, no stall, no redirect: instr<=imem_rdata, instr_pc<=fetched_pc, instr_valid<=inflight; fetched_pc<=pc, inflight<=1, pc<=pc+1.
  - RUN, stall=1, no redirect: all registers hold; imem_en=0 so imem_rdata stays valid.
  - Redirect, any state including BOOT, HALT or stall:
    - instr_valid<=0 (squash IF/ID) and instr<=0.
    - fetched_pc<=target, inflight<=1, pc<=target+1, state<=RUN.
    - Exactly one bubble: mem[target] appears at instr with instr_valid=1 after the next non-stalled edge.
  - HALT: see Optional Feature.
- Latency: an address issued at edge N appears in instr at edge N+1. From reset release, instr_valid is first high after the 2nd rising edge.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (16'hFFFF -> 16'h0000) with no flag.
- Stall and redirect together: redirect wins; the stall is ignored for that edge.
- Reset mid-operation (during stall or redirect): reset values apply at that edge; the in-flight word is discarded.
- opcode is purely combinational from instr. It is 3'b000 after reset, but instr_valid=0 there, so the decoder must qualify on instr_valid.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - When a non-stalled RUN edge loads a word with opcode==HALT_OPCODE and inflight=1, that instruction is passed with instr_valid=1.
  - On the same edge: state<=HALT, inflight<=0.
  - In HALT: imem_en=0, pc and fetched_pc hold, halted=1. On subsequent non-stalled edges, instr_valid<=0.
  - Only reset or redirect leaves HALT; a redirect enters RUN per the redirect rule.
- Undefined: HALT state is unreachable, halted is tied to 0, and HALT_OPCODE is decoded as an ordinary instruction.

Test Plan:
- Reset hold 3 cycles, release, mem[i]=16'h1000+i, no stall -> imem_addr=0,1,2 on successive cycles; after edge 2 instr=16'h1000, instr_pc=0, instr_valid=1; then one new word per cycle.
- Stall=1 for 3 cycles while instr_pc=5 -> instr/instr_pc hold at mem[5]/5 and imem_en=0 throughout; after release the next valid instr_pc is 6 with no skip or duplicate.
- branch_taken=1, branch_target=16'h0040 while instr_pc=7 -> same cycle imem_addr=16'h0040; next edge instr_valid=0; following edge instr_pc=16'h0040, instr=mem[16'h40], instr_valid=1.
- jump=1 (target 16'h0100) with branch_taken=1 (target 16'h0200) and stall=1 simultaneously -> imem_addr=16'h0100; sequence resumes at 16'h0100; stall ignored that edge.
- PC reaches 16'hFFFF -> next fetch address 16'h0000; instr_pc sequence FFFE, FFFF, 0000 with instr_valid=1 throughout.
- FETCH_HALT_EN defined, mem[3]=16'hE000 -> instr_pc=3 valid once, then halted=1, imem_en=0, instr_valid=0; jump to 16'h0010 -> halted=0 and fetch resumes at 16'h0010 after one bubble.
